local_ni: RTL and testbench
===========================

# local_ni

Local network interface for one mesh node, sitting between the processing core and the router's local (L) port. On the inject side it stamps core requests into 40-bit flits (source, destination, timestamp, payload, type), buffers them, and launches them into the router only when the router's local FIFO is neither full nor congested. On the eject side it captures flits leaving the router's L port, computes their network latency, and presents them to the core through a small buffer. The router's L output has no backpressure, so overflowing flits are dropped and counted.

## Interface
- NODE_ID, 4'd0, this node's address, written into the src field
- DATASIZE, 40, flit width; layout is src[39:36], dst[35:32], timestamp[31:24], data[23:2], type[1:0]
- DEPTH, 8, inject FIFO entries
- WIDTH, 3, log2(DEPTH); pressure inputs are WIDTH+1 bits
- THROTTLE, 4'd6, inject is blocked while the router's L pressure is greater than or equal to this value
- EJ_DEPTH, 4, eject FIFO entries (power of 2)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- core_valid  in  1  core request valid
- core_ready  out  1  NI can accept a request
- core_dst  in  4  destination node
- core_data  in  22  payload
- core_type  in  2  flit type
- inj_data  out  DATASIZE  flit to the router's L_data_in
- inj_valid  out  1  one-cycle pulse per flit, to the router's L_valid_in
- inj_full  in  1  router L FIFO full
- inj_pressure  in  WIDTH+1  router L FIFO occupancy
- ej_data  in  DATASIZE  flit from the router's L_data_out
- ej_valid  in  1  ejected flit valid
- rx_valid  out  1  eject FIFO non-empty (show-ahead)
- rx_ready  in  1  core consumes the head entry
- rx_src  out  4  head entry source
- rx_data  out  22  head entry payload
- rx_type  out  2  head entry type
- rx_latency  out  8  head entry latency in cycles
- tx_count  out  16  flits injected, wraps
- rx_count  out  16  flits accepted into the eject FIFO, wraps
- drop_count  out  8  flits dropped on eject overflow, saturates at 255
- misroute  out  1  sticky; set when an ejected flit has dst != NODE_ID

## Operation
- ts: free-running 8-bit counter. Reset value 0; increments every cycle; wraps 255 -> 0.
- Enqueue:
  - A request is accepted on a rising edge where core_valid && core_ready.
  - The stored flit is {NODE_ID, core_dst, ts, core_data, core_type}, where ts is the value sampled at that edge.
  - core_ready = (inject count != DEPTH), driven from the registered count only.
- Launch:
  - Condition: FIFO non-empty (registered) && !inj_full && inj_pressure < THROTTLE.
  - When the condition holds, the head entry is popped and registered into inj_data, and inj_valid = 1 for that cycle. Otherwise inj_valid = 0 and inj_data holds its last value.
  - Back-to-back launches are allowed, one per cycle.
  - tx_count increments on every inj_valid pulse.
- Simultaneous push and pop on the inject FIFO are both honoured. The count is unchanged and the pointers wrap modulo DEPTH.
- Eject:
  - On an edge with ej_valid, the entry {src, data, type, latency = ts - timestamp (8-bit modular)} is pushed if the eject FIFO is not full, or if it is full and a pop occurs on the same edge.
  - Otherwise the flit is dropped and drop_count increments, saturating at 255.
  - rx_count increments on every accepted push.
  - If dst != NODE_ID, misroute is set to 1 and stays set until reset; the flit is still accepted.
- rx_* outputs reflect the eject FIFO head. A pop happens when rx_valid && rx_ready; rx_ready is ignored while the FIFO is empty.
- Reset (asynchronous, may occur mid-operation):
  - Both FIFOs are flushed.
  - ts, all counters and misroute are cleared to 0.
  - inj_valid = 0, inj_data = 0, rx_valid = 0.
  - core_ready = 1 as soon as rst deasserts.

## Timing
- Inject latency: for a request accepted at edge E into an empty FIFO, with launch conditions met, inj_valid is high in the cycle after edge E+1. Minimum core-to-router latency is 2 edges.
- Throughput is 1 flit per cycle when the launch conditions hold continuously.
- The inj_full and inj_pressure values sampled at a given edge decide the launch at that edge. There is no combinational path from them to inj_valid within a cycle.
- Eject: a flit with ej_valid at edge E appears on rx_* after edge E, provided the FIFO was empty. rx_latency is computed using the ts value at edge E.
- Latency arithmetic: latency = ts - timestamp, 8-bit modular. This is exact for network latency up to 255 cycles.

## Test plan
- Single request: after reset, request dst=5, data=22'h1234, type=2 at ts=3 -> exactly one inj_valid pulse 2 edges later with inj_data={4'd0, 4'd5, 8'd3, 22'h1234, 2'd2}; tx_count=1.
- Fill and backpressure: hold inj_full=1 and push 9 requests -> core_ready drops after the 8th. Release inj_full -> 8 consecutive inj_valid pulses in FIFO order.
- Throttle: inj_pressure=6 -> no launches. inj_pressure=5 -> launches resume the next edge.
- Latency wrap: inject an ejected flit with timestamp=250 at ts=4 -> rx_latency=10.
- Eject overflow: rx_ready=0 and 5 consecutive ej_valid flits -> 4 accepted, drop_count=1. Raise rx_ready together with a 6th flit while full -> flit accepted, no drop.
- Misroute and reset: eject a flit with dst=3 at NODE_ID=0 -> misroute=1. Assert rst mid-stream -> all outputs and counters go to 0 immediately, and misroute clears.

Source files
------------

// File: rtl/local_ni_if.sv
// Handshake bundle between the local NI, the processing core and the router L port.
// The slave modport is the NI's view; master is the surrounding core/router side.
interface local_ni_if #(
  parameter int unsigned DATASIZE = 40,
  parameter int unsigned WIDTH    = 3
);
  // Core request side
  logic                core_valid;
  logic                core_ready;
  logic [3:0]          core_dst;
  logic [21:0]         core_data;
  logic [1:0]          core_type;

  // Router L input (inject)
  logic [DATASIZE-1:0] inj_data;
  logic                inj_valid;
  logic                inj_full;
  logic [WIDTH:0]      inj_pressure;

  // Router L output (eject)
  logic [DATASIZE-1:0] ej_data;
  logic                ej_valid;

  // Core receive side
  logic                rx_valid;
  logic                rx_ready;
  logic [3:0]          rx_src;
  logic [21:0]         rx_data;
  logic [1:0]          rx_type;
  logic [7:0]          rx_latency;

  modport slave (
    input  core_valid, core_dst, core_data, core_type,
    output core_ready,
    output inj_data, inj_valid,
    input  inj_full, inj_pressure,
    input  ej_data, ej_valid,
    output rx_valid, rx_src, rx_data, rx_type, rx_latency,
    input  rx_ready
  );

  modport master (
    output core_valid, core_dst, core_data, core_type,
    input  core_ready,
    input  inj_data, inj_valid,
    output inj_full, inj_pressure,
    output ej_data, ej_valid,
    input  rx_valid, rx_src, rx_data, rx_type, rx_latency,
    output rx_ready
  );
endinterface

// File: rtl/local_ni.sv
// Local network interface: stamps core requests into flits for the router L port and
// buffers ejected flits for the core, measuring their network latency.
module local_ni #(
  parameter logic [3:0]  NODE_ID  = 4'd0,
  parameter int unsigned DATASIZE = 40,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WIDTH    = 3,
  parameter logic [3:0]  THROTTLE = 4'd6,
  parameter int unsigned EJ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  local_ni_if.slave   bus,
  output logic [15:0] tx_count,
  output logic [15:0] rx_count,
  output logic [7:0]  drop_count,
  output logic        misroute
);

  localparam int unsigned EjW = $clog2(EJ_DEPTH);

  typedef struct packed {
    logic [3:0]  src;
    logic [21:0] data;
    logic [1:0]  typ;
    logic [7:0]  lat;
  } ej_entry_t;

  logic [7:0] ts;

  // ---------------------------------------------------------------------------
  // Inject path
  // ---------------------------------------------------------------------------
  logic [DATASIZE-1:0] inj_mem [DEPTH];
  logic [WIDTH-1:0]    inj_wr;
  logic [WIDTH-1:0]    inj_rd;
  logic [WIDTH:0]      inj_cnt;
  logic                inj_push;
  logic                inj_pop;
  logic [DATASIZE-1:0] inj_flit;

  function automatic logic [WIDTH-1:0] inj_next(input logic [WIDTH-1:0] p);
    return (p == WIDTH'(DEPTH - 1)) ? '0 : p + WIDTH'(1);
  endfunction

  assign bus.core_ready = (inj_cnt != (WIDTH+1)'(DEPTH));
  assign inj_push       = bus.core_valid && bus.core_ready;
  // Launch decision uses only registered occupancy and the sampled router status.
  assign inj_pop        = (inj_cnt != '0) && !bus.inj_full &&
                          (bus.inj_pressure < (WIDTH+1)'(THROTTLE));
  assign inj_flit       = DATASIZE'({NODE_ID, bus.core_dst, ts, bus.core_data, bus.core_type});

  always_ff @(posedge clk) begin
    if (inj_push) inj_mem[inj_wr] <= inj_flit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts            <= '0;
      inj_wr        <= '0;
      inj_rd        <= '0;
      inj_cnt       <= '0;
      bus.inj_data  <= '0;
      bus.inj_valid <= 1'b0;
      tx_count      <= '0;
    end else begin
      ts            <= ts + 8'd1;
      bus.inj_valid <= inj_pop;
      if (inj_push) inj_wr <= inj_next(inj_wr);
      if (inj_pop) begin
        bus.inj_data <= inj_mem[inj_rd];
        inj_rd       <= inj_next(inj_rd);
        tx_count     <= tx_count + 16'd1;
      end
      unique case ({inj_push, inj_pop})
        2'b10:   inj_cnt <= inj_cnt + (WIDTH+1)'(1);
        2'b01:   inj_cnt <= inj_cnt - (WIDTH+1)'(1);
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Eject path
  // ---------------------------------------------------------------------------
  ej_entry_t      ej_mem [EJ_DEPTH];
  ej_entry_t      ej_in;
  ej_entry_t      ej_head;
  logic [EjW-1:0] ej_wr;
  logic [EjW-1:0] ej_rd;
  logic [EjW:0]   ej_cnt;
  logic           ej_full;
  logic           ej_push;
  logic           ej_drop;
  logic           rx_pop;

  assign ej_full = (ej_cnt == (EjW+1)'(EJ_DEPTH));
  assign rx_pop  = bus.rx_valid && bus.rx_ready;
  // A pop on the same edge frees a slot, so a full FIFO can still take the flit.
  assign ej_push = bus.ej_valid && (!ej_full || rx_pop);
  assign ej_drop = bus.ej_valid && !ej_push;

  always_comb begin
    ej_in      = '0;
    ej_in.src  = bus.ej_data[39:36];
    ej_in.data = bus.ej_data[23:2];
    ej_in.typ  = bus.ej_data[1:0];
    ej_in.lat  = ts - bus.ej_data[31:24];
  end

  always_ff @(posedge clk) begin
    if (ej_push) ej_mem[ej_wr] <= ej_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ej_wr      <= '0;
      ej_rd      <= '0;
      ej_cnt     <= '0;
      rx_count   <= '0;
      drop_count <= '0;
      misroute   <= 1'b0;
    end else begin
      if (ej_push) begin
        ej_wr    <= ej_wr + EjW'(1);
        rx_count <= rx_count + 16'd1;
      end
      if (rx_pop) ej_rd <= ej_rd + EjW'(1);
      if (ej_drop && (drop_count != 8'hff)) drop_count <= drop_count + 8'd1;
      if (bus.ej_valid && (bus.ej_data[35:32] != NODE_ID)) misroute <= 1'b1;
      unique case ({ej_push, rx_pop})
        2'b10:   ej_cnt <= ej_cnt + (EjW+1)'(1);
        2'b01:   ej_cnt <= ej_cnt - (EjW+1)'(1);
        default: ;
      endcase
    end
  end

  // Show-ahead head; fields read as zero while empty so stale entries never leak out.
  always_comb begin
    ej_head        = ej_mem[ej_rd];
    bus.rx_valid   = (ej_cnt != '0);
    bus.rx_src     = '0;
    bus.rx_data    = '0;
    bus.rx_type    = '0;
    bus.rx_latency = '0;
    if (bus.rx_valid) begin
      bus.rx_src     = ej_head.src;
      bus.rx_data    = ej_head.data;
      bus.rx_type    = ej_head.typ;
      bus.rx_latency = ej_head.lat;
    end
  end

endmodule

// File: tb/tb_local_ni.sv
// Scoreboard bench for local_ni: stimulus pushes expected flits/entries into queues,
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_local_ni;

  localparam logic [3:0] NodeId = 4'd0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] tx_count;
  logic [15:0] rx_count;
  logic [7:0]  drop_count;
  logic        misroute;

  int compared   = 0;
  int mismatched = 0;

  logic [39:0] inj_q [$];
  logic [35:0] rx_q  [$];
  logic [7:0]  model_ts;

  local_ni_if #(.DATASIZE(40), .WIDTH(3)) bus ();

  local_ni #(
    .NODE_ID  (NodeId),
    .DATASIZE (40),
    .DEPTH    (8),
    .WIDTH    (3),
    .THROTTLE (4'd6),
    .EJ_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .tx_count   (tx_count),
    .rx_count   (rx_count),
    .drop_count (drop_count),
    .misroute   (misroute)
  );

  always #5 clk = ~clk;

  // Reference timestamp: value the DUT samples at the next rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) model_ts <= 8'd0;
    else     model_ts <= model_ts + 8'd1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.inj_valid) begin
        if (inj_q.size() == 0) chk("inj_unexpected", 64'd1, 64'd0);
        else                   chk("inj_data", 64'(bus.inj_data), 64'(inj_q.pop_front()));
      end
      if (bus.rx_valid && bus.rx_ready) begin
        if (rx_q.size() == 0) chk("rx_unexpected", 64'd1, 64'd0);
        else chk("rx_entry", 64'({bus.rx_src, bus.rx_data, bus.rx_type, bus.rx_latency}),
                 64'(rx_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] dst, input logic [21:0] d, input logic [1:0] t);
    bus.core_valid = 1'b1;
    bus.core_dst   = dst;
    bus.core_data  = d;
    bus.core_type  = t;
    if (bus.core_ready) inj_q.push_back({NodeId, dst, model_ts, d, t});
    step();
    bus.core_valid = 1'b0;
  endtask

  task automatic eject(input logic [3:0] src, input logic [3:0] dst, input logic [7:0] tsf,
                       input logic [21:0] d, input logic [1:0] t, input bit accept,
                       input logic [7:0] exp_lat);
    bus.ej_valid = 1'b1;
    bus.ej_data  = {src, dst, tsf, d, t};
    if (accept) rx_q.push_back({src, d, t, exp_lat});
    step();
    bus.ej_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bus.core_valid   = 1'b0;
    bus.core_dst     = '0;
    bus.core_data    = '0;
    bus.core_type    = '0;
    bus.inj_full     = 1'b0;
    bus.inj_pressure = '0;
    bus.ej_data      = '0;
    bus.ej_valid     = 1'b0;
    bus.rx_ready     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_core_ready", 64'(bus.core_ready), 64'd1);
    chk("rst_inj_valid",  64'(bus.inj_valid),  64'd0);
    chk("rst_inj_data",   64'(bus.inj_data),   64'd0);
    chk("rst_rx_valid",   64'(bus.rx_valid),   64'd0);
    chk("rst_counts",     64'({tx_count, rx_count, drop_count, misroute}), 64'd0);

    // Single request at ts=3: lands on the router 2 edges after acceptance
    repeat (3) step();
    bus.core_valid = 1'b1;
    bus.core_dst   = 4'd5;
    bus.core_data  = 22'h1234;
    bus.core_type  = 2'd2;
    inj_q.push_back(40'h05030048D2);
    step();
    bus.core_valid = 1'b0;
    chk("single_no_early", 64'(bus.inj_valid), 64'd0);
    step();
    chk("single_pulse", 64'(bus.inj_valid), 64'd1);
    step();
    chk("single_one_pulse", 64'(bus.inj_valid), 64'd0);
    chk("single_tx_count", 64'(tx_count), 64'd1);

    // Fill and backpressure
    bus.inj_full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("fill_core_ready", 64'(bus.core_ready), (i < 8) ? 64'd1 : 64'd0);
      send(4'(i + 1), 22'h3F000 + 22'(i), 2'(i));
    end
    chk("fill_no_launch", 64'(bus.inj_valid), 64'd0);
    bus.inj_full = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("drain_pulse", 64'(bus.inj_valid), 64'd1);
    end
    step();
    chk("drain_done", 64'(bus.inj_valid), 64'd0);
    chk("drain_tx_count", 64'(tx_count), 64'd9);

    // Throttle at pressure 6, release at 5
    bus.inj_pressure = 4'd6;
    send(4'd7, 22'h155555, 2'd1);
    send(4'd8, 22'h0AAAAA, 2'd3);
    for (int i = 0; i < 3; i++) begin
      chk("throttle_block", 64'(bus.inj_valid), 64'd0);
      step();
    end
    bus.inj_pressure = 4'd5;
    step();
    chk("throttle_resume0", 64'(bus.inj_valid), 64'd1);
    step();
    chk("throttle_resume1", 64'(bus.inj_valid), 64'd1);
    step();
    chk("throttle_idle", 64'(bus.inj_valid), 64'd0);
    bus.inj_pressure = 4'd0;
    chk("throttle_tx_count", 64'(tx_count), 64'd11);

    // Latency wrap: timestamp 250 ejected at ts 4
    for (int i = 0; i < 300 && model_ts != 8'd4; i++) step();
    eject(4'd7, NodeId, 8'd250, 22'h3ABCD, 2'd1, 1'b1, 8'd10);
    chk("lat_rx_valid", 64'(bus.rx_valid), 64'd1);
    chk("lat_value", 64'(bus.rx_latency), 64'd10);
    bus.rx_ready = 1'b1;
    step();
    bus.rx_ready = 1'b0;
    chk("lat_popped", 64'(bus.rx_valid), 64'd0);

    // Eject overflow: 4 accepted, 1 dropped
    for (int i = 0; i < 5; i++)
      eject(4'(i + 1), NodeId, model_ts - 8'd3, 22'h100 + 22'(i), 2'(i), i < 4, 8'd3);
    chk("ovf_drop", 64'(drop_count), 64'd1);
    chk("ovf_rx_count", 64'(rx_count), 64'd5);
    bus.rx_ready = 1'b1;
    eject(4'd9, NodeId, model_ts - 8'd3, 22'h2222, 2'd2, 1'b1, 8'd3);
    chk("ovf_pop_push_drop", 64'(drop_count), 64'd1);
    chk("ovf_pop_push_rx_count", 64'(rx_count), 64'd6);
    for (int i = 0; i < 10 && bus.rx_valid; i++) step();
    bus.rx_ready = 1'b0;
    chk("ovf_drained", 64'(bus.rx_valid), 64'd0);
    chk("no_misroute_yet", 64'(misroute), 64'd0);

    // Misroute, then asynchronous reset with both FIFOs occupied
    bus.inj_full = 1'b1;
    send(4'd4, 22'h0BEEF, 2'd0);
    eject(4'd2, 4'd3, model_ts - 8'd1, 22'h0CAFE, 2'd3, 1'b1, 8'd1);
    chk("misroute_set", 64'(misroute), 64'd1);
    chk("misroute_accepted", 64'(bus.rx_valid), 64'd1);
    chk("misroute_rx_count", 64'(rx_count), 64'd7);
    #2 rst = 1'b1;
    inj_q.delete();
    rx_q.delete();
    #1;
    chk("arst_inj_valid", 64'(bus.inj_valid), 64'd0);
    chk("arst_inj_data",  64'(bus.inj_data),  64'd0);
    chk("arst_rx_valid",  64'(bus.rx_valid),  64'd0);
    chk("arst_rx_fields", 64'({bus.rx_src, bus.rx_data, bus.rx_type, bus.rx_latency}), 64'd0);
    chk("arst_counts",    64'({tx_count, rx_count, drop_count, misroute}), 64'd0);
    bus.inj_full = 1'b0;
    step();
    rst = 1'b0;
    chk("post_rst_core_ready", 64'(bus.core_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_flushed", 64'(bus.inj_valid), 64'd0);
      chk("post_rst_rx_empty", 64'(bus.rx_valid), 64'd0);
    end
    send(4'd9, 22'h2AAAA, 2'd3);
    step();
    step();
    chk("post_rst_tx_count", 64'(tx_count), 64'd1);
    repeat (3) step();
    chk("inj_q_empty", 64'(inj_q.size()), 64'd0);
    chk("rx_q_empty",  64'(rx_q.size()),  64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
